fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch/next-PC stage feeding cpu_control. Holds the PC and fetches each 16-bit instruction over a req/valid port.
//  Presents opcode instr[15:12] for decode and owns the Z/V/N flag register. Evaluates B/BR conditions and
//  computes the next PC. Sequences fetch -> execute and stops on HLT or on a fetch timeout.
// PARAMETERS
//  RESET_PC      16'h0000  PC value loaded on reset
//  FETCH_TIMEOUT 8         max cycles waiting for imem_valid before fetch_err (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  imem_req    out  1   fetch request, high only in FETCH
//  imem_addr   out  16  fetch address = pc
//  imem_valid  in   1   imem_data valid this cycle (sampled only in FETCH)
//  imem_data   in   16  instruction word
//  instr       out  16  latched instruction, stable through EXEC
//  opcode      out  4   instr[15:12], to cpu_control.control
//  instr_valid out  1   high exactly during the EXEC cycle
//  pc_source   in   1   PCSource from cpu_control: 1 = B/BR candidate
//  reg_target  in   16  register value for BR target
//  alu_z       in   1   ALU zero result, valid in EXEC
//  alu_v       in   1   ALU overflow result, valid in EXEC
//  alu_n       in   1   ALU negative result, valid in EXEC
//  flags       out  3   {Z,V,N} flag register
//  pc_plus2    out  16  pc+2 (PCS writeback value)
//  halted      out  1   sticky, set on HLT or fetch_err
//  fetch_err   out  1   sticky, set on fetch timeout
// BEHAVIOUR
//  Reset (rst=1 at a clock edge; dominates every other event):
//  - pc=RESET_PC, instr=16'h0000, flags=3'b000, state=FETCH, wait_cnt=0, halted=0, fetch_err=0
//  - Resulting outputs: imem_req=1, instr_valid=0
//  FSM states: FETCH, EXEC, HALT.
//  - FETCH: imem_req=1. If imem_valid=1: instr<=imem_data, wait_cnt<=0, next EXEC.
//    Otherwise wait_cnt++; at wait_cnt==FETCH_TIMEOUT-1 with no valid, fetch_err<=1, halted<=1, next HALT.
//  - EXEC: one cycle, instr_valid=1, imem_valid ignored.
//    opcode==4'hF: pc unchanged (points at HLT), halted<=1, next HALT.
//    Else pc<=next_pc, next FETCH.
//  - HALT: terminal. imem_req=0, instr_valid=0, all registers hold. Exit only by rst.
//  Fetch latency: minimum 2 cycles per instruction (FETCH with imem_valid, then EXEC).
//  next_pc (16-bit wrap-around, no overflow flag):
//  - pc_source=1, opcode 4'hC (B), cond true: pc+2 + {{6{instr[8]}},instr[8:0],1'b0}
//  - pc_source=1, opcode 4'hD (BR), cond true: reg_target
//  - All other cases: pc+2
//  cond = f(ccc=instr[11:9], flags register value before this EXEC's update):
//  - 000 NE: !Z.   001 EQ: Z.   010 GT: !Z&!N.   011 LT: N
//  - 100 GE: Z|(!Z&!N).   101 LE: N|Z.   110 OV: V.   111 always
//  Flag update at the end of EXEC:
//  - ADD(0)/SUB(1): Z,V,N <= alu_z,alu_v,alu_n
//  - XOR(2)/SLL(4)/SRA(5)/ROR(6): Z only
//  - All other opcodes: flags hold
//  - A branch reads the flags written by the prior instruction; there is no same-cycle bypass.
//  pc_plus2 is combinational from pc and wraps 16'hFFFE -> 16'h0000.
// STRUCTURE
//  cpu_pkg:
//  - opcode localparams OP_ADD..OP_HLT, ccc localparams CC_NE..CC_UNC
//  - state encoding ST_FETCH/ST_EXEC/ST_HALT, flag bit indices FLG_Z/FLG_V/FLG_N
//  Sub-module branch_cond_eval (combinational): inputs ccc[2:0], flags[2:0]; output taken.
//  The FSM, PC, flag register and timeout counter live in fetch_pc_unit.
// TESTING
//  - Reset, imem_valid=1 every cycle, ADD stream:
//    imem_addr = 0,2,4... every 2 cycles, instr_valid alternates 1/0.
//  - SUB with alu_z=1, then B EQ (instr=16'hC204, imm=4), B at pc=16'h0010:
//    next imem_addr=16'h001A. Same with Z=0: 16'h0012.
//  - BR unconditional (ccc=111), reg_target=16'h1234: next imem_addr=16'h1234.
//    Then XOR with alu_v=1,alu_n=1,alu_z=0: flags V,N unchanged, Z=0.
//  - HLT at pc=16'h0008: halted=1 after EXEC, imem_req=0, pc stays 16'h0008 for 20 cycles.
//    rst -> pc=RESET_PC, halted=0.
//  - FETCH_TIMEOUT=8 with imem_valid held 0: fetch_err=halted=1 after exactly 8 FETCH cycles.
//    imem_valid=1 on the 8th cycle: no error, EXEC follows.
//  - Branch at pc=16'hFFFC with imm=+2 wraps to 16'h0002.
//    rst asserted during EXEC: no flag/pc update, FETCH at RESET_PC next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/next-PC stage: opcodes, branch condition
// codes, FSM states and flag bit positions, plus the branch offset helper.
package cpu_pkg;

    // Opcodes carried in instr[15:12]
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Branch condition codes carried in instr[11:9]
    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Flag register layout is {Z,V,N}
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    // Signed 9-bit word offset from instr[8:0], scaled to bytes
    function automatic logic [15:0] branch_offset(input logic [15:0] instr);
        return {{6{instr[8]}}, instr[8:0], 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a B/BR condition code against the flag register.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLG_Z];
    assign v = flags[FLG_V];
    assign n = flags[FLG_N];

    // Decode the condition code into a single taken bit
    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:   taken = !z;
            CC_EQ:   taken = z;
            CC_GT:   taken = !z && !n;
            CC_LT:   taken = n;
            CC_GE:   taken = z || (!z && !n);
            CC_LE:   taken = n || z;
            CC_OV:   taken = v;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/next-PC stage: holds the PC, fetches one instruction per FETCH over
// a req/valid port, presents it for one EXEC cycle, owns the {Z,V,N} flags
// and resolves B/BR targets. Stops for good on HLT or a fetch timeout.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int          FETCH_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic        instr_valid,
    input  logic        pc_source,
    input  logic [15:0] reg_target,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    output logic [2:0]  flags,
    output logic [15:0] pc_plus2,
    output logic        halted,
    output logic        fetch_err
);

    // The wait counter only ever needs to reach FETCH_TIMEOUT-1
    localparam int              CNT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [2:0]        flags_q, flags_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              halted_q, halted_d;
    logic              fetch_err_q, fetch_err_d;

    logic [3:0]        op;
    logic [15:0]       pc_inc;
    logic              cond_taken;
    logic [15:0]       next_pc;

    assign op     = instr_q[15:12];
    assign pc_inc = pc_q + 16'd2;

    // Condition is judged on the flags as they stood before this EXEC
    branch_cond_eval u_cond (
        .ccc   (instr_q[11:9]),
        .flags (flags_q),
        .taken (cond_taken)
    );

    // Select the sequential, relative-branch or register-branch target
    always_comb begin
        next_pc = pc_inc;
        if (pc_source && cond_taken) begin
            if (op == OP_B) begin
                next_pc = pc_inc + branch_offset(instr_q);
            end else if (op == OP_BR) begin
                next_pc = reg_target;
            end
        end
    end

    // FSM next state, fetch capture, timeout, PC advance and flag update
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        flags_d     = flags_q;
        wait_cnt_d  = wait_cnt_q;
        halted_d    = halted_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    instr_d    = imem_data;
                    wait_cnt_d = '0;
                    state_d    = ST_EXEC;
                end else if (wait_cnt_q == CNT_LAST) begin
                    fetch_err_d = 1'b1;
                    halted_d    = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_EXEC: begin
                if (op == OP_HLT) begin
                    // PC is left pointing at the HLT itself
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
                case (op)
                    OP_ADD, OP_SUB: begin
                        flags_d[FLG_Z] = alu_z;
                        flags_d[FLG_V] = alu_v;
                        flags_d[FLG_N] = alu_n;
                    end
                    OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                        flags_d[FLG_Z] = alu_z;
                    end
                    default: begin
                        flags_d = flags_q;
                    end
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register; reset overrides any in-flight update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            flags_q     <= 3'b000;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            flags_q     <= flags_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = op;
    assign instr_valid = (state_q == ST_EXEC);
    assign flags       = flags_q;
    assign pc_plus2    = pc_inc;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;

endmodule
